imm_gen: RTL and testbench
==========================

IMM_GEN -- requirements
Module: imm_gen

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high (ports clk, rst).
REQ-002 The block SHALL have no parameters; widths are fixed at 32-bit RV32I.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 instr  input  32  raw RV32I instruction word, sampled every rising edge.
REQ-006 imm  output  32  sign-extended immediate decoded from instr (registered).
REQ-007 i_instr  output  1  high when the sampled instr is I-type (registered).
REQ-008 s_instr  output  1  high when the sampled instr is S-type (registered).
REQ-009 fmt  output  3  format code: 0 R/other, 1 I, 2 S, 3 B, 4 U, 5 J (registered).

Function
REQ-010 Decode SHALL use opcode instr[6:0] only; funct3/funct7 SHALL NOT affect decoding.
REQ-011 I-type opcodes SHALL be 0000011, 0010011, 1100111, 1110011; imm = sext(instr[31:20]).
REQ-012 S-type opcode SHALL be 0100011; imm = sext({instr[31:25], instr[11:7]}).
REQ-013 B-type opcode SHALL be 1100011; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
REQ-014 U-type opcodes SHALL be 0110111, 0010111; imm = {instr[31:12], 12'b0}.
REQ-015 J-type opcode SHALL be 1101111; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-016 R-type (0110011) and every unlisted opcode SHALL produce imm = 0, fmt = 0, i_instr = 0, s_instr = 0.
REQ-017 Sign extension SHALL replicate instr[31] into all bits above the field's MSB.
REQ-018 OP-IMM shift forms (funct3 001/101) SHALL be treated as ordinary I-type (funct7 bits kept in imm[11:5]).
REQ-019 i_instr SHALL equal (fmt == 1) and s_instr SHALL equal (fmt == 2); the two SHALL never be high together.
REQ-020 Latency SHALL be exactly one cycle: outputs after rising edge N reflect instr sampled at edge N.
REQ-021 Outputs SHALL update every cycle with no handshake or enable; they SHALL be stable between edges.
REQ-022 X/undefined opcode bits SHALL NOT be special-cased; unlisted opcode rule (REQ-016) applies.

Reset
REQ-023 While rst is high at a rising edge, imm SHALL become 0, fmt 0, i_instr 0, s_instr 0.
REQ-024 Reset SHALL take priority over decode; the first decoded result SHALL appear one edge after the edge where rst is low.
REQ-025 Reset asserted mid-stream SHALL discard the instr sampled on that edge.

Verification
REQ-026 rst=1 for 2 edges, any instr -> imm=0x00000000, fmt=0, i_instr=0, s_instr=0.
REQ-027 instr=0xFE0070B3 (R-type) -> imm=0x00000000, fmt=0; then instr=0xAAA07083 (I, load) -> imm=0xFFFFFAAA, fmt=1, i_instr=1.
REQ-028 instr=0x54007AA3 (S) -> imm=0x00000555, fmt=2, s_instr=1; instr=0xAA007563 (B) -> imm=0xFFFFF2AA, fmt=3.
REQ-029 instr=0xFFFFF0B7 (LUI) -> imm=0xFFFFF000, fmt=4; instr=0x000010EF (JAL) -> imm=0x00001000, fmt=5.
REQ-030 Back-to-back stream of the above, one per cycle -> each result appears exactly one edge after its sample, no stalls; rst pulsed mid-stream -> zeros for that cycle, decode resumes next.

Source files
------------

// File: rtl/imm_gen.sv
// RV32I immediate generator: decodes the opcode of each sampled instruction
// word into a format code and its sign-extended immediate, one cycle later.
module imm_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   output logic [31:0] imm,
   output logic        i_instr,
   output logic        s_instr,
   output logic [2:0]  fmt
);

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [6:0]  opcode;
   fmt_t        next_fmt;
   logic [31:0] next_imm;

   // Only the opcode selects the format; unknown or X opcodes fall to R/other.
   always_comb begin
      opcode   = instr[6:0];
      next_fmt = FMT_R;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: next_fmt = FMT_I;
         OP_STORE:                            next_fmt = FMT_S;
         OP_BRANCH:                           next_fmt = FMT_B;
         OP_LUI, OP_AUIPC:                    next_fmt = FMT_U;
         OP_JAL:                              next_fmt = FMT_J;
         default:                             next_fmt = FMT_R;
      endcase
   end

   always_comb begin
      next_imm = 32'd0;
      case (next_fmt)
         FMT_I: next_imm = {{20{instr[31]}}, instr[31:20]};
         FMT_S: next_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B: next_imm = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
         FMT_U: next_imm = {instr[31:12], 12'd0};
         FMT_J: next_imm = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
         default: next_imm = 32'd0;
      endcase
   end

   // Reset wins over decode, so the word sampled on a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         imm     <= 32'd0;
         fmt     <= 3'd0;
         i_instr <= 1'b0;
         s_instr <= 1'b0;
      end else begin
         imm     <= next_imm;
         fmt     <= next_fmt;
         i_instr <= (next_fmt == FMT_I);
         s_instr <= (next_fmt == FMT_S);
      end
   end

endmodule

// File: tb/tb_imm_gen.sv
// Bench for imm_gen: directed vector table, reset corner cases, then a
// randomized stream checked against a field-arithmetic reference model.
module tb_imm_gen;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic [31:0] imm;
   logic        i_instr;
   logic        s_instr;
   logic [2:0]  fmt;

   int checks = 0;
   int failures = 0;

   imm_gen dut (
      .clk     (clk),
      .rst     (rst),
      .instr   (instr),
      .imm     (imm),
      .i_instr (i_instr),
      .s_instr (s_instr),
      .fmt     (fmt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] word;
      logic        rst;
      logic [31:0] exp_imm;
      logic [2:0]  exp_fmt;
   } vec_t;

   typedef struct {
      logic [31:0] imm;
      logic [2:0]  fmt;
   } ref_t;

   // Reference decode built from the architectural field rules with arithmetic shifts.
   function automatic ref_t refModel(input logic [31:0] w);
      ref_t        r;
      logic [31:0] sgn;
      sgn = 32'($signed(w) >>> 31);
      r.imm = 32'd0;
      r.fmt = 3'd0;
      case (w[6:0])
         7'h03, 7'h13, 7'h67, 7'h73: begin
            r.fmt = 3'd1;
            r.imm = 32'($signed(w) >>> 20);
         end
         7'h23: begin
            r.fmt = 3'd2;
            r.imm = (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]);
         end
         7'h63: begin
            r.fmt = 3'd3;
            r.imm = (sgn << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5)
                  | (32'(w[11:8]) << 1);
         end
         7'h37, 7'h17: begin
            r.fmt = 3'd4;
            r.imm = w & 32'hFFFF_F000;
         end
         7'h6F: begin
            r.fmt = 3'd5;
            r.imm = (sgn << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
                  | (32'(w[30:21]) << 1);
         end
         default: ;
      endcase
      return r;
   endfunction

   task automatic applyStimulus(input logic [31:0] w, input logic r);
      @(negedge clk);
      instr = w;
      rst   = r;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] e_imm,
                              input logic [2:0] e_fmt);
      logic e_i;
      logic e_s;
      e_i = (e_fmt == 3'd1);
      e_s = (e_fmt == 3'd2);
      checks++;
      if (imm !== e_imm || fmt !== e_fmt || i_instr !== e_i || s_instr !== e_s) begin
         failures++;
         $display("[TB] FAIL %s: got imm=%h fmt=%0d i=%b s=%b, expected imm=%h fmt=%0d i=%b s=%b",
                  name, imm, fmt, i_instr, s_instr, e_imm, e_fmt, e_i, e_s);
      end
   endtask

   vec_t vecs[$];

   initial begin
      ref_t        r;
      logic [31:0] w;
      logic        rb;
      logic [6:0]  ops[10];

      instr = 32'hFFFF_FFFF;
      rst   = 1'b1;

      // Reset for two edges with a busy instruction word on the bus.
      applyStimulus(32'hAAA0_7083, 1'b1);
      checkOutput("reset_edge1", 32'd0, 3'd0);
      applyStimulus(32'h0000_10EF, 1'b1);
      checkOutput("reset_edge2", 32'd0, 3'd0);

      vecs.push_back('{"r_type",      32'hFE00_70B3, 1'b0, 32'h0000_0000, 3'd0});
      vecs.push_back('{"i_load",      32'hAAA0_7083, 1'b0, 32'hFFFF_FAAA, 3'd1});
      vecs.push_back('{"s_store",     32'h5400_7AA3, 1'b0, 32'h0000_0555, 3'd2});
      vecs.push_back('{"b_branch",    32'hAA00_7563, 1'b0, 32'hFFFF_F2AA, 3'd3});
      vecs.push_back('{"u_lui",       32'hFFFF_F0B7, 1'b0, 32'hFFFF_F000, 3'd4});
      vecs.push_back('{"j_jal",       32'h0000_10EF, 1'b0, 32'h0000_1000, 3'd5});
      vecs.push_back('{"mid_reset",   32'hAAA0_7083, 1'b1, 32'h0000_0000, 3'd0});
      vecs.push_back('{"resume_s",    32'h5400_7AA3, 1'b0, 32'h0000_0555, 3'd2});
      vecs.push_back('{"srai_shift",  32'h4050_5093, 1'b0, 32'h0000_0405, 3'd1});
      vecs.push_back('{"jalr_neg",    32'h8000_8067, 1'b0, 32'hFFFF_F800, 3'd1});
      vecs.push_back('{"ecall",       32'h0000_0073, 1'b0, 32'h0000_0000, 3'd1});
      vecs.push_back('{"auipc",       32'h1234_5017, 1'b0, 32'h1234_5000, 3'd4});
      vecs.push_back('{"b_min",       32'h8000_0063, 1'b0, 32'hFFFF_F000, 3'd3});
      vecs.push_back('{"j_min",       32'h8000_00EF, 1'b0, 32'hFFF0_0000, 3'd5});
      vecs.push_back('{"s_neg",       32'hFE00_0FA3, 1'b0, 32'hFFFF_FFFF, 3'd2});
      vecs.push_back('{"fence_other", 32'hFFFF_FF0F, 1'b0, 32'h0000_0000, 3'd0});
      vecs.push_back('{"unlisted",    32'hFFFF_FF7F, 1'b0, 32'h0000_0000, 3'd0});

      // Table entries go in back-to-back, one per cycle, with no idle cycles.
      foreach (vecs[k]) begin
         applyStimulus(vecs[k].word, vecs[k].rst);
         checkOutput(vecs[k].name, vecs[k].exp_imm, vecs[k].exp_fmt);
      end

      // Outputs must hold steady until the next rising edge.
      applyStimulus(32'hAAA0_7083, 1'b0);
      @(negedge clk);
      instr = 32'h5400_7AA3;
      #3;
      checkOutput("hold_between_edges", 32'hFFFF_FAAA, 3'd1);
      @(posedge clk);
      #1;
      checkOutput("after_hold", 32'h0000_0555, 3'd2);

      ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
      for (int n = 0; n < 300; n++) begin
         w = $urandom;
         if ($urandom_range(0, 4) != 0)
            w[6:0] = ops[$urandom_range(0, 9)];
         rb = ($urandom_range(0, 15) == 0);
         applyStimulus(w, rb);
         if (rb) begin
            checkOutput("rand_reset", 32'd0, 3'd0);
         end else begin
            r = refModel(w);
            checkOutput($sformatf("rand_%h", w), r.imm, r.fmt);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
